reimu_shot_ctrl: RTL and testbench

- Schedules and tracks the player's shots fired from the player position.
- Each clk22 tick it:
  - enforces a fire-rate cooldown,
  - allocates a free shot slot from a fixed pool,
  - advances every live shot upward,
  - retires shots that leave the playfield top or are reported as hits.
- Sits between the player-movement block (which supplies the position) and the renderer / collision logic (which consume the slot vectors).

---
 rtl/reimu_shot_ctrl_pkg.sv | 16 +
 rtl/reimu_shot_ctrl_slot.sv | 69 ++++++
 rtl/reimu_shot_ctrl.sv | 132 +++++++++++++
 tb/tb_reimu_shot_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/reimu_shot_ctrl_pkg.sv
// rtl/reimu_shot_ctrl_pkg.sv - shared playfield bounds, coordinate width and fire FSM encoding
package reimu_shot_ctrl_pkg;

  localparam int COORD_W = 10;

  localparam logic [COORD_W-1:0] PLAY_TOP_Y    = 10'd25;
  localparam logic [COORD_W-1:0] PLAY_BOTTOM_Y = 10'd465;
  localparam logic [COORD_W-1:0] PLAY_LEFT_X   = 10'd24;
  localparam logic [COORD_W-1:0] PLAY_RIGHT_X  = 10'd430;

  typedef enum logic {
    READY = 1'b0,
    COOL  = 1'b1
  } fire_state_e;

endpackage

// File: rtl/reimu_shot_ctrl_slot.sv
// rtl/reimu_shot_ctrl_slot.sv - one shot slot: valid/x/y with hit, retire, move and spawn priority
module shot_slot
  import reimu_shot_ctrl_pkg::*;
#(
  parameter int SHOT_SPEED = 14,
  parameter int TOP_Y      = 25
) (
  input  logic               clk22,
  input  logic               rst,
  input  logic               clr,
  input  logic               spawn,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [COORD_W-1:0] spawn_y,
  input  logic               hit,
  output logic               valid,
  output logic               valid_next,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [COORD_W-1:0] SPEED    = COORD_W'(SHOT_SPEED);
  localparam logic [COORD_W-1:0] RETIRE_Y = COORD_W'(TOP_Y + SHOT_SPEED);

  logic               valid_q, valid_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;

  // A live slot never accepts a spawn, so a retiring slot frees up one tick later.
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (clr) begin
      valid_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
    end else if (valid_q) begin
      if (hit) begin
        valid_d = 1'b0;
      end else if (y_q < RETIRE_Y) begin
        valid_d = 1'b0;
      end else begin
        y_d = y_q - SPEED;
      end
    end else if (spawn) begin
      valid_d = 1'b1;
      x_d     = spawn_x;
      y_d     = spawn_y;
    end
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign valid      = valid_q;
  assign valid_next = valid_d;
  assign x          = x_q;
  assign y          = y_q;

endmodule

// File: rtl/reimu_shot_ctrl.sv
// rtl/reimu_shot_ctrl.sv - player shot scheduler: cooldown FSM, slot allocator and live-shot count
module reimu_shot_ctrl
  import reimu_shot_ctrl_pkg::*;
#(
  parameter int NSHOT      = 4,
  parameter int COOLDOWN   = 4,
  parameter int SHOT_SPEED = 14,
  parameter int SPAWN_DY   = 12,
  parameter int TOP_Y      = 25
) (
  input  logic                       clk22,
  input  logic                       rst,
  input  logic                       gamestart,
  input  logic                       shoot,
  input  logic [9:0]                 reimux,
  input  logic [9:0]                 reimuy,
  input  logic [NSHOT-1:0]           hit,
  output logic [NSHOT-1:0]           shot_valid,
  output logic [10*NSHOT-1:0]        shotx,
  output logic [10*NSHOT-1:0]        shoty,
  output logic                       shot_fire,
  output logic [$clog2(NSHOT+1)-1:0] shot_cnt
);

  localparam int CNT_W = $clog2(COOLDOWN + 1);
  localparam int POP_W = $clog2(NSHOT + 1);

  fire_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               shot_fire_q, shot_fire_d;
  logic [POP_W-1:0]   shot_cnt_q, shot_cnt_d;

  logic [NSHOT-1:0]   free_slots;
  logic [NSHOT-1:0]   first_free;
  logic [NSHOT-1:0]   spawn_vec;
  logic [NSHOT-1:0]   valid_next;
  logic               any_free;
  logic               fire;
  logic [COORD_W-1:0] spawn_y;

  // Allocation looks only at registered validity, isolating the lowest clear bit.
  assign free_slots = ~shot_valid;
  assign first_free = free_slots & (~free_slots + NSHOT'(1));
  assign any_free   = |free_slots;
  assign spawn_vec  = fire ? first_free : '0;
  assign spawn_y    = reimuy - COORD_W'(SPAWN_DY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (gamestart) begin
      state_d = READY;
      cnt_d   = '0;
    end else begin
      case (state_q)
        READY: begin
          if (shoot && any_free) begin
            fire = 1'b1;
            if (COOLDOWN > 1) begin
              state_d = COOL;
              cnt_d   = CNT_W'(COOLDOWN - 1);
            end
          end
        end
        COOL: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = READY;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    shot_fire_d = fire;
    shot_cnt_d  = '0;
    for (int i = 0; i < NSHOT; i++) begin
      shot_cnt_d = shot_cnt_d + POP_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q     <= READY;
      cnt_q       <= '0;
      shot_fire_q <= 1'b0;
      shot_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shot_fire_q <= shot_fire_d;
      shot_cnt_q  <= shot_cnt_d;
    end
  end

  always_ff @(posedge clk22) begin
    if (!rst && fire) begin
      assert (reimuy > 10'(SPAWN_DY));
    end
  end

  for (genvar i = 0; i < NSHOT; i++) begin : g_slot
    shot_slot #(
      .SHOT_SPEED (SHOT_SPEED),
      .TOP_Y      (TOP_Y)
    ) u_slot (
      .clk22      (clk22),
      .rst        (rst),
      .clr        (gamestart),
      .spawn      (spawn_vec[i]),
      .spawn_x    (reimux),
      .spawn_y    (spawn_y),
      .hit        (hit[i]),
      .valid      (shot_valid[i]),
      .valid_next (valid_next[i]),
      .x          (shotx[10*i +: 10]),
      .y          (shoty[10*i +: 10])
    );
  end

  assign shot_fire = shot_fire_q;
  assign shot_cnt  = shot_cnt_q;

endmodule

// File: tb/tb_reimu_shot_ctrl.sv
// tb/tb_reimu_shot_ctrl.sv - scoreboard bench for reimu_shot_ctrl
module tb_reimu_shot_ctrl;

  logic        clk22 = 1'b0;
  logic        rst;
  logic        gamestart;
  logic        shoot;
  logic [9:0]  reimux;
  logic [9:0]  reimuy;
  logic [3:0]  hit;
  logic [3:0]  shot_valid;
  logic [39:0] shotx;
  logic [39:0] shoty;
  logic        shot_fire;
  logic [2:0]  shot_cnt;

  typedef struct {
    string      name;
    int         due;
    logic [3:0] valid;
    logic       fire;
    logic [2:0] cnt;
    int         slot;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  reimu_shot_ctrl dut (
    .clk22      (clk22),
    .rst        (rst),
    .gamestart  (gamestart),
    .shoot      (shoot),
    .reimux     (reimux),
    .reimuy     (reimuy),
    .hit        (hit),
    .shot_valid (shot_valid),
    .shotx      (shotx),
    .shoty      (shoty),
    .shot_fire  (shot_fire),
    .shot_cnt   (shot_cnt)
  );

  always #5 clk22 = ~clk22;

  always @(posedge clk22) cyc <= cyc + 1;

  // Expected state after the next rising edge, given the inputs now driven.
  task automatic expect_st(input string name, input logic [3:0] v, input logic f,
                           input logic [2:0] c, input int slot,
                           input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.name = name; e.due = cyc + 1; e.valid = v; e.fire = f; e.cnt = c;
    e.slot = slot; e.x = x; e.y = y;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk22);
  endtask

  initial begin
    forever begin
      @(negedge clk22);
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        logic ok;
        logic [9:0] ax, ay;
        e = q.pop_front();
        ax = 10'd0; ay = 10'd0;
        ok = (shot_valid === e.valid) && (shot_fire === e.fire) && (shot_cnt === e.cnt);
        if (e.slot >= 0) begin
          ax = shotx[e.slot*10 +: 10];
          ay = shoty[e.slot*10 +: 10];
          ok = ok && (ax === e.x) && (ay === e.y);
        end
        tests_run++;
        if (!ok) begin
          tests_failed++;
          $display("FAIL %s: got valid=%b fire=%b cnt=%0d x=%0d y=%0d, want valid=%b fire=%b cnt=%0d slot%0d x=%0d y=%0d",
                   e.name, shot_valid, shot_fire, shot_cnt, ax, ay,
                   e.valid, e.fire, e.cnt, e.slot, e.x, e.y);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "watchdog");
  end

  task automatic autofire(input string name, input int n);
    for (int k = 1; k <= n; k++) begin
      int live;
      live = (k + 3) / 4;
      expect_st(name, 4'((1 << live) - 1), (k % 4) == 1, 3'(live),
                ((k % 4) == 1) ? live - 1 : -1, reimux, reimuy - 10'd12);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; gamestart = 1'b0; shoot = 1'b0; hit = 4'b0000;
    reimux = 10'd0; reimuy = 10'd100;
    expect_st("reset", 4'b0000, 1'b0, 3'd0, 0, 10'd0, 10'd0);
    tick();
    rst = 1'b0;

    // Single shot
    reimux = 10'd220; reimuy = 10'd360; shoot = 1'b1;
    expect_st("single_fire", 4'b0001, 1'b1, 3'd1, 0, 10'd220, 10'd348);
    tick();
    shoot = 1'b0;
    expect_st("single_move", 4'b0001, 1'b0, 3'd1, 0, 10'd220, 10'd334);
    tick();
    gamestart = 1'b1;
    expect_st("clear1", 4'b0000, 1'b0, 3'd0, 0, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0;

    // Auto-fire fills slots 0..3 on ticks 1,5,9,13
    reimux = 10'd100; reimuy = 10'd400; shoot = 1'b1;
    autofire("autofire", 12);
    expect_st("autofire_13", 4'b1111, 1'b1, 3'd4, 3, 10'd100, 10'd388);
    expect_st("autofire_slot0_y", 4'b1111, 1'b1, 3'd4, 0, 10'd100, 10'd220);
    tick();

    // Pool full: no fire even once cooldown has expired
    for (int k = 14; k <= 18; k++) begin
      expect_st("pool_full", 4'b1111, 1'b0, 3'd4, 3, 10'd100, 10'(388 - 14 * (k - 13)));
      tick();
    end
    hit = 4'b0100;
    expect_st("hit_slot2", 4'b1011, 1'b0, 3'd3, 2, 10'd100, 10'd262);
    tick();
    hit = 4'b0000; reimux = 10'd300; reimuy = 10'd200;
    expect_st("refill_slot2", 4'b1111, 1'b1, 3'd4, 2, 10'd300, 10'd188);
    tick();
    shoot = 1'b0; gamestart = 1'b1;
    expect_st("clear2", 4'b0000, 1'b0, 3'd0, 2, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0;

    // Top retire without wrap
    reimux = 10'd50; reimuy = 10'd40; shoot = 1'b1;
    expect_st("spawn_y28", 4'b0001, 1'b1, 3'd1, 0, 10'd50, 10'd28);
    tick();
    shoot = 1'b0;
    expect_st("retire_y28", 4'b0000, 1'b0, 3'd0, 0, 10'd50, 10'd28);
    tick();
    gamestart = 1'b1; shoot = 1'b1; reimuy = 10'd25;
    expect_st("clear_beats_fire", 4'b0000, 1'b0, 3'd0, 0, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0;
    expect_st("spawn_y13", 4'b0001, 1'b1, 3'd1, 0, 10'd50, 10'd13);
    tick();
    shoot = 1'b0;
    expect_st("retire_y13", 4'b0000, 1'b0, 3'd0, -1, 10'd0, 10'd0);
    tick();

    // Hit beats move; hit on an invalid slot is ignored
    gamestart = 1'b1;
    expect_st("clear3", 4'b0000, 1'b0, 3'd0, -1, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0; reimux = 10'd10; reimuy = 10'd300; shoot = 1'b1;
    expect_st("sim_fire", 4'b0001, 1'b1, 3'd1, 0, 10'd10, 10'd288);
    tick();
    shoot = 1'b0; hit = 4'b0011;
    expect_st("sim_hit0_holds", 4'b0000, 1'b0, 3'd0, 0, 10'd10, 10'd288);
    expect_st("sim_hit1_ignored", 4'b0000, 1'b0, 3'd0, 1, 10'd0, 10'd0);
    tick();
    hit = 4'b0000;

    // Clear during cooldown with three live shots
    gamestart = 1'b1;
    expect_st("clear4", 4'b0000, 1'b0, 3'd0, -1, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0; reimux = 10'd60; reimuy = 10'd400; shoot = 1'b1;
    autofire("refire", 10);
    gamestart = 1'b1;
    expect_st("clear_in_cool", 4'b0000, 1'b0, 3'd0, 2, 10'd0, 10'd0);
    tick();
    gamestart = 1'b0; reimux = 10'd77; reimuy = 10'd100;
    expect_st("fire_after_clear", 4'b0001, 1'b1, 3'd1, 0, 10'd77, 10'd88);
    tick();
    shoot = 1'b0;

    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    if (q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
